// File: rtl/uart_mem_bridge.sv
// UART-to-BRAM debug bridge: host byte commands drive masked single writes,
// burst writes and inclusive range reads on a dual-port BRAM.
//
// state    | meaning
// IDLE     | wait for opcode byte
// W_ADDR   | collect single-write address
// W_MASK   | collect byte-enable mask
// W_DATA   | collect single-write word
// W_COMMIT | one-cycle masked write on port A
// B_ADDR   | collect burst start address
// B_COUNT  | collect burst word count (0 = 256)
// B_DATA   | collect one burst word
// B_COMMIT | one-cycle full-word write, advance address
// ACK      | send 0xA5, wait for TX_done
// R_ADDR   | collect low then high read address
// R_FETCH  | addrb presented, BRAM latency cycle
// R_WAIT   | dob valid, capture and launch first byte
// R_SEND   | stream remaining bytes of the word
// R_ERR    | send 0xEE, wait for TX_done
module uart_mem_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    byte_done,
  input  logic [7:0]              RX_data,
  input  logic                    TX_done,
  input  logic [8*DATA_BYTES-1:0] dob,
  output logic                    TX_enable,
  output logic [7:0]              TX_data,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [DATA_BYTES-1:0]   wea,
  output logic [8*DATA_BYTES-1:0] dia,
  output logic [ADDR_WIDTH-1:0]   addrb,
  output logic                    busy
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int DW         = 8 * DATA_BYTES;
  localparam int AW8        = 8 * ADDR_BYTES;
  localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BYTES - 1);
  localparam logic [4:0] RANGE_LAST = 5'(2 * ADDR_BYTES - 1);
  localparam logic [4:0] DATA_LAST  = 5'(DATA_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_BYTES);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_MASK, W_DATA, W_COMMIT, B_ADDR, B_COUNT, B_DATA,
    B_COMMIT, ACK, R_ADDR, R_FETCH, R_WAIT, R_SEND, R_ERR
  } state_t;

  state_t state, state_nxt;

  logic [4:0]            byte_cnt;
  logic [4:0]            send_cnt;
  logic [AW8-1:0]        addr_sh, addr_next;
  logic [ADDR_WIDTH-1:0] field_addr, waddr, low_addr, high_addr;
  logic [DW-1:0]         data_sh, data_next, rd_sh, rd_shift8;
  logic [DATA_BYTES-1:0] mask;
  logic [8:0]            burst_left;
  logic [TW-1:0]         tmo_cnt;
  logic [ADDR_WIDTH:0]   next_word;
  logic                  rx_state, timeout, range_err, last_word, tx_start;
  logic [7:0]            tx_byte;

  // Little-endian fields: each new byte enters at the top and slides down.
  assign addr_next  = (addr_sh >> 8) | (AW8'(RX_data) << (AW8 - 8));
  assign data_next  = (data_sh >> 8) | (DW'(RX_data) << (DW - 8));
  assign field_addr = addr_next[ADDR_WIDTH-1:0];
  assign rd_shift8  = rd_sh >> 8;
  assign next_word  = {1'b0, addrb} + {1'b0, STEP};
  assign last_word  = next_word[ADDR_WIDTH] || (next_word[ADDR_WIDTH-1:0] > high_addr);
  assign range_err  = field_addr < low_addr;
  assign rx_state   = state inside {W_ADDR, W_MASK, W_DATA, B_ADDR, B_COUNT, B_DATA, R_ADDR};
  assign timeout    = rx_state && !byte_done && (tmo_cnt == '0);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_byte   = 8'h00;
    wea       = '0;
    case (state)
      IDLE: if (byte_done) begin
        case (RX_data)
          8'h0F:   state_nxt = W_ADDR;
          8'hF0:   state_nxt = B_ADDR;
          8'hFF:   state_nxt = R_ADDR;
          default: state_nxt = IDLE;
        endcase
      end
      W_ADDR:  if (byte_done && byte_cnt == ADDR_LAST) state_nxt = W_MASK;
      W_MASK:  if (byte_done) state_nxt = W_DATA;
      W_DATA:  if (byte_done && byte_cnt == DATA_LAST) state_nxt = W_COMMIT;
      W_COMMIT: begin
        wea       = mask;
        state_nxt = ACK;
        tx_start  = 1'b1;
        tx_byte   = 8'hA5;
      end
      B_ADDR:  if (byte_done && byte_cnt == ADDR_LAST) state_nxt = B_COUNT;
      B_COUNT: if (byte_done) state_nxt = B_DATA;
      B_DATA:  if (byte_done && byte_cnt == DATA_LAST) state_nxt = B_COMMIT;
      B_COMMIT: begin
        wea = '1;
        if (burst_left == 9'd1) begin
          state_nxt = ACK;
          tx_start  = 1'b1;
          tx_byte   = 8'hA5;
        end else begin
          state_nxt = B_DATA;
        end
      end
      ACK:     if (TX_done) state_nxt = IDLE;
      R_ADDR: if (byte_done && byte_cnt == RANGE_LAST) begin
        if (range_err) begin
          state_nxt = R_ERR;
          tx_start  = 1'b1;
          tx_byte   = 8'hEE;
        end else begin
          state_nxt = R_FETCH;
        end
      end
      R_FETCH: state_nxt = R_WAIT;
      R_WAIT: begin
        state_nxt = R_SEND;
        tx_start  = 1'b1;
        tx_byte   = dob[7:0];
      end
      R_SEND: if (TX_done) begin
        if (send_cnt == DATA_LAST) begin
          state_nxt = last_word ? IDLE : R_FETCH;
        end else begin
          tx_start = 1'b1;
          tx_byte  = rd_shift8[7:0];
        end
      end
      R_ERR:   if (TX_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      send_cnt   <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      rd_sh      <= '0;
      waddr      <= '0;
      low_addr   <= '0;
      high_addr  <= '0;
      mask       <= '0;
      burst_left <= '0;
      tmo_cnt    <= '0;
      addra      <= '0;
      dia        <= '0;
      addrb      <= '0;
      TX_enable  <= 1'b0;
      TX_data    <= 8'h00;
    end else begin
      TX_enable <= tx_start;
      if (tx_start) TX_data <= tx_byte;

      if (!rx_state || byte_done) tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (tmo_cnt != '0)     tmo_cnt <= tmo_cnt - 1'b1;

      case (state)
        IDLE: byte_cnt <= '0;
        W_ADDR, B_ADDR: if (byte_done) begin
          addr_sh <= addr_next;
          if (byte_cnt == ADDR_LAST) begin
            byte_cnt <= '0;
            waddr    <= field_addr;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        W_MASK:  if (byte_done) mask <= RX_data[DATA_BYTES-1:0];
        B_COUNT: if (byte_done) burst_left <= (RX_data == 8'h00) ? 9'd256 : {1'b0, RX_data};
        W_DATA, B_DATA: if (byte_done) begin
          data_sh <= data_next;
          if (byte_cnt == DATA_LAST) begin
            byte_cnt <= '0;
            addra    <= waddr;
            dia      <= data_next;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        B_COMMIT: begin
          waddr      <= waddr + STEP;
          burst_left <= burst_left - 9'd1;
        end
        R_ADDR: if (byte_done) begin
          addr_sh <= addr_next;
          if (byte_cnt == ADDR_LAST) low_addr <= field_addr;
          if (byte_cnt == RANGE_LAST) begin
            byte_cnt  <= '0;
            high_addr <= field_addr;
            if (!range_err) addrb <= low_addr;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        R_WAIT: begin
          rd_sh    <= dob;
          send_cnt <= '0;
        end
        R_SEND: if (TX_done) begin
          rd_sh    <= rd_shift8;
          send_cnt <= send_cnt + 1'b1;
          if (send_cnt == DATA_LAST && !last_word) addrb <= next_word[ADDR_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: a 16-bit/32-bit instance and a
// 12-bit/16-bit instance, each with a BRAM model and a UART TX responder.
`timescale 1ns/1ps
module tb_uart_mem_bridge;

  logic clk, rst_n;
  int checks, errors;

  logic        byte_done1, tx_done1, tx_en1, busy1;
  logic [7:0]  rx1, tx_data1;
  logic [31:0] dob1, dia1;
  logic [15:0] addra1, addrb1;
  logic [3:0]  wea1;

  logic        byte_done2, tx_done2, tx_en2, busy2;
  logic [7:0]  rx2, tx_data2;
  logic [15:0] dob2, dia2;
  logic [11:0] addra2, addrb2;
  logic [1:0]  wea2;

  logic [7:0]  txq1[$], txq2[$];
  logic [15:0] wl_addr1[$];
  logic [31:0] wl_data1[$];
  logic [3:0]  wl_wea1[$];
  logic [11:0] wl_addr2[$];
  logic [15:0] wl_data2[$];
  logic [1:0]  wl_wea2[$];

  logic [31:0] mem1 [0:16383];
  logic [15:0] mem2 [0:2047];

  uart_mem_bridge #(.ADDR_WIDTH(16), .DATA_BYTES(4), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .byte_done(byte_done1), .RX_data(rx1), .TX_done(tx_done1),
    .dob(dob1), .TX_enable(tx_en1), .TX_data(tx_data1), .addra(addra1), .wea(wea1),
    .dia(dia1), .addrb(addrb1), .busy(busy1));

  uart_mem_bridge #(.ADDR_WIDTH(12), .DATA_BYTES(2), .TIMEOUT_CYCLES(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .byte_done(byte_done2), .RX_data(rx2), .TX_done(tx_done2),
    .dob(dob2), .TX_enable(tx_en2), .TX_data(tx_data2), .addra(addra2), .wea(wea2),
    .dia(dia2), .addrb(addrb2), .busy(busy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM models: read-first, one-cycle read latency
  initial begin
    for (int i = 0; i < 16384; i++) mem1[i] <= 32'h5A000000 | i;
    for (int i = 0; i < 2048; i++) mem2[i] <= 16'h0000;
    dob1 <= '0;
    dob2 <= '0;
    forever begin
      @(posedge clk);
      dob1 <= mem1[addrb1[15:2]];
      dob2 <= mem2[addrb2[11:1]];
      for (int b = 0; b < 4; b++)
        if (wea1[b]) mem1[addra1[15:2]][8*b +: 8] <= dia1[8*b +: 8];
      for (int b = 0; b < 2; b++)
        if (wea2[b]) mem2[addra2[11:1]][8*b +: 8] <= dia2[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (|wea1) begin wl_addr1.push_back(addra1); wl_data1.push_back(dia1); wl_wea1.push_back(wea1); end
    if (|wea2) begin wl_addr2.push_back(addra2); wl_data2.push_back(dia2); wl_wea2.push_back(wea2); end
  end

  // UART TX responders: TX_done two cycles after each TX_enable
  initial begin
    tx_done1 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done1 = 1'b0;
      if (tx_en1 === 1'b1) begin
        txq1.push_back(tx_data1);
        repeat (2) @(negedge clk);
        tx_done1 = 1'b1;
      end
    end
  end

  initial begin
    tx_done2 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done2 = 1'b0;
      if (tx_en2 === 1'b1) begin
        txq2.push_back(tx_data2);
        repeat (2) @(negedge clk);
        tx_done2 = 1'b1;
      end
    end
  end

  task automatic send1(input logic [7:0] b);
    @(negedge clk);
    rx1 = b; byte_done1 = 1'b1;
    @(negedge clk);
    byte_done1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    @(negedge clk);
    rx2 = b; byte_done2 = 1'b1;
    @(negedge clk);
    byte_done2 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (((which == 1) ? busy1 : busy2) !== 1'b0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (((which == 1) ? busy1 : busy2) !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait dut%0d busy=%b after %0d cycles, required 0", which, (which == 1) ? busy1 : busy2, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({tx_en1, tx_data1, addra1, wea1, dia1, addrb1, busy1} !== '0) begin
      errors++;
      $display("FAIL reset_out1 got en=%b tx=%h aa=%h wea=%h dia=%h ab=%h busy=%b, required all 0",
               tx_en1, tx_data1, addra1, wea1, dia1, addrb1, busy1);
    end
    checks++;
    if ({tx_en2, tx_data2, addra2, wea2, dia2, addrb2, busy2} !== '0) begin
      errors++;
      $display("FAIL reset_out2 got en=%b tx=%h aa=%h wea=%h dia=%h ab=%h busy=%b, required all 0",
               tx_en2, tx_data2, addra2, wea2, dia2, addrb2, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ignore_opcode;
    send1(8'h55);
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || txq1.size() != 0) begin
      errors++;
      $display("FAIL bad_opcode busy=%b tx=%0d, required busy 0 tx 0", busy1, txq1.size());
    end
  endtask

  task automatic test_single_write;
    int wb;
    wb = wl_addr1.size();
    txq1.delete();
    send1(8'h0F); send1(8'h10); send1(8'h00); send1(8'h05);
    send1(8'hEF); send1(8'hBE); send1(8'hAD); send1(8'hDE);
    checks++;
    if (wea1 !== 4'b0101 || addra1 !== 16'h0010 || dia1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_commit got wea=%b aa=%h dia=%h, required 0101 0010 deadbeef", wea1, addra1, dia1);
    end
    @(negedge clk);
    checks++;
    if (wea1 !== 4'b0000 || tx_en1 !== 1'b1 || tx_data1 !== 8'hA5 || addra1 !== 16'h0010) begin
      errors++;
      $display("FAIL sw_ack_start got wea=%b en=%b tx=%h aa=%h, required 0 1 a5 0010", wea1, tx_en1, tx_data1, addra1);
    end
    wait_idle(1);
    checks++;
    if (txq1.size() != 1 || txq1[0] !== 8'hA5 || wl_addr1.size() != wb + 1) begin
      errors++;
      $display("FAIL sw_reply got tx_count=%0d writes=%0d, required 1 byte a5 and 1 write", txq1.size(), wl_addr1.size() - wb);
    end
    checks++;
    if (mem1[4] !== 32'h5AAD00EF) begin
      errors++;
      $display("FAIL sw_mem got %h, required 5aad00ef", mem1[4]);
    end
  endtask

  task automatic test_burst_and_read;
    int wb, bad;
    logic [31:0] ew;
    wb = wl_addr1.size();
    txq1.delete();
    send1(8'hF0); send1(8'h20); send1(8'h00); send1(8'h03);
    for (int i = 1; i <= 12; i++) send1(8'(i));
    wait_idle(1);
    checks++;
    if (wl_addr1.size() != wb + 3 || txq1.size() != 1 || txq1[0] !== 8'hA5) begin
      errors++;
      $display("FAIL burst_count got writes=%0d tx=%0d, required 3 writes and ack a5", wl_addr1.size() - wb, txq1.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        ew = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        checks++;
        if (wl_addr1[wb+k] !== 16'(32 + 4*k) || wl_wea1[wb+k] !== 4'hF || wl_data1[wb+k] !== ew) begin
          errors++;
          $display("FAIL burst_word%0d got aa=%h wea=%h dia=%h, required %h f %h",
                   k, wl_addr1[wb+k], wl_wea1[wb+k], wl_data1[wb+k], 16'(32 + 4*k), ew);
        end
      end
    end
    txq1.delete();
    send1(8'hFF); send1(8'h20); send1(8'h00); send1(8'h28); send1(8'h00);
    checks++;
    if (addrb1 !== 16'h0020) begin
      errors++;
      $display("FAIL read_addrb got %h, required 0020", addrb1);
    end
    @(negedge clk);
    checks++;
    if (tx_en1 !== 1'b0) begin
      errors++;
      $display("FAIL read_early_tx got en=%b, required 0", tx_en1);
    end
    @(negedge clk);
    checks++;
    if (tx_en1 !== 1'b1 || tx_data1 !== 8'h01) begin
      errors++;
      $display("FAIL read_first_tx got en=%b tx=%h, required 1 01", tx_en1, tx_data1);
    end
    wait_idle(1);
    bad = 0;
    for (int i = 0; i < txq1.size() && i < 12; i++) if (txq1[i] !== 8'(i + 1)) bad++;
    checks++;
    if (txq1.size() != 12 || bad != 0 || addrb1 !== 16'h0028) begin
      errors++;
      $display("FAIL read_bytes got count=%0d wrong=%0d addrb=%h, required 12 0 0028", txq1.size(), bad, addrb1);
    end
  endtask

  task automatic test_range_error;
    txq1.delete();
    send1(8'hFF); send1(8'h10); send1(8'h00); send1(8'h08); send1(8'h00);
    checks++;
    if (tx_en1 !== 1'b1 || tx_data1 !== 8'hEE || addrb1 !== 16'h0028) begin
      errors++;
      $display("FAIL rerr_start got en=%b tx=%h addrb=%h, required 1 ee 0028", tx_en1, tx_data1, addrb1);
    end
    wait_idle(1);
    checks++;
    if (txq1.size() != 1 || txq1[0] !== 8'hEE || addrb1 !== 16'h0028) begin
      errors++;
      $display("FAIL rerr_reply got count=%0d addrb=%h, required 1 byte ee, addrb 0028", txq1.size(), addrb1);
    end
  endtask

  task automatic test_top_read;
    logic [7:0] exp8 [8];
    int bad;
    exp8 = '{8'hFE, 8'h3F, 8'h00, 8'h5A, 8'hFF, 8'h3F, 8'h00, 8'h5A};
    txq1.delete();
    send1(8'hFF); send1(8'hF8); send1(8'hFF); send1(8'hFF); send1(8'hFF);
    wait_idle(1);
    bad = 0;
    for (int i = 0; i < txq1.size() && i < 8; i++) if (txq1[i] !== exp8[i]) bad++;
    checks++;
    if (txq1.size() != 8 || bad != 0 || addrb1 !== 16'hFFFC) begin
      errors++;
      $display("FAIL top_read got count=%0d wrong=%0d addrb=%h, required 8 0 fffc", txq1.size(), bad, addrb1);
    end
  endtask

  task automatic test_timeout;
    int wb;
    wb = wl_addr1.size();
    txq1.delete();
    send1(8'h0F); send1(8'h10); send1(8'h00); send1(8'h05); send1(8'hAA);
    repeat (50) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got busy=%b, required 1", busy1);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || wl_addr1.size() != wb || txq1.size() != 0) begin
      errors++;
      $display("FAIL tmo_abort got busy=%b writes=%0d tx=%0d, required 0 0 0", busy1, wl_addr1.size() - wb, txq1.size());
    end
    send1(8'h0F); send1(8'h40); send1(8'h00); send1(8'h0F);
    send1(8'h44); send1(8'h33); send1(8'h22); send1(8'h11);
    wait_idle(1);
    checks++;
    if (wl_addr1.size() != wb + 1 || txq1.size() != 1) begin
      errors++;
      $display("FAIL tmo_recover got writes=%0d tx=%0d, required 1 1", wl_addr1.size() - wb, txq1.size());
    end else if (wl_addr1[wb] !== 16'h0040 || wl_data1[wb] !== 32'h11223344 || wl_wea1[wb] !== 4'hF || txq1[0] !== 8'hA5) begin
      errors++;
      $display("FAIL tmo_recover_data got aa=%h dia=%h wea=%h tx=%h, required 0040 11223344 f a5",
               wl_addr1[wb], wl_data1[wb], wl_wea1[wb], txq1[0]);
    end
  endtask

  task automatic test_reset_mid_ops;
    int wb, n;
    wb = wl_addr1.size();
    send1(8'hF0); send1(8'h30); send1(8'h00); send1(8'h02);
    for (int i = 0; i < 6; i++) send1(8'h70 + 8'(i));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_en1, tx_data1, addra1, wea1, dia1, addrb1, busy1} !== '0) begin
      errors++;
      $display("FAIL rst_burst got en=%b aa=%h wea=%h dia=%h ab=%h busy=%b, required all 0",
               tx_en1, addra1, wea1, dia1, addrb1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wl_addr1.size() != wb + 1 || wl_addr1[wb] !== 16'h0030) begin
      errors++;
      $display("FAIL rst_burst_writes got %0d writes, required exactly 1 at 0030", wl_addr1.size() - wb);
    end
    txq1.delete();
    send1(8'hFF); send1(8'h00); send1(8'h00); send1(8'hFF); send1(8'h00);
    n = 0;
    while (txq1.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (txq1.size() < 2) begin
      errors++;
      $display("FAIL rst_read_wait got %0d bytes after %0d cycles, required 2", txq1.size(), n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_en1, tx_data1, addra1, wea1, dia1, addrb1, busy1} !== '0) begin
      errors++;
      $display("FAIL rst_read got en=%b tx=%h ab=%h busy=%b, required all 0", tx_en1, tx_data1, addrb1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    txq1.delete();
    send1(8'h0F); send1(8'h50); send1(8'h00); send1(8'h01);
    send1(8'h77); send1(8'h00); send1(8'h00); send1(8'h00);
    checks++;
    if (wea1 !== 4'b0001 || addra1 !== 16'h0050 || dia1 !== 32'h00000077) begin
      errors++;
      $display("FAIL rst_recover got wea=%b aa=%h dia=%h, required 0001 0050 00000077", wea1, addra1, dia1);
    end
    wait_idle(1);
    checks++;
    if (txq1.size() != 1 || txq1[0] !== 8'hA5) begin
      errors++;
      $display("FAIL rst_recover_ack got count=%0d, required 1 byte a5", txq1.size());
    end
  endtask

  task automatic test_small_cfg;
    int wb;
    txq2.delete();
    send2(8'h0F); send2(8'h34); send2(8'hF2); send2(8'h03); send2(8'hCD); send2(8'hAB);
    checks++;
    if (wea2 !== 2'b11 || addra2 !== 12'h234 || dia2 !== 16'hABCD) begin
      errors++;
      $display("FAIL small_sw got wea=%b aa=%h dia=%h, required 11 234 abcd", wea2, addra2, dia2);
    end
    wait_idle(2);
    checks++;
    if (txq2.size() != 1 || txq2[0] !== 8'hA5) begin
      errors++;
      $display("FAIL small_sw_ack got count=%0d, required 1 byte a5", txq2.size());
    end
    wb = wl_addr2.size();
    txq2.delete();
    send2(8'hF0); send2(8'hFE); send2(8'h0F); send2(8'h02);
    send2(8'h01); send2(8'h02); send2(8'h03); send2(8'h04);
    wait_idle(2);
    checks++;
    if (wl_addr2.size() != wb + 2 || txq2.size() != 1) begin
      errors++;
      $display("FAIL small_burst got writes=%0d tx=%0d, required 2 1", wl_addr2.size() - wb, txq2.size());
    end else if (wl_addr2[wb] !== 12'hFFE || wl_data2[wb] !== 16'h0201 ||
                 wl_addr2[wb+1] !== 12'h000 || wl_data2[wb+1] !== 16'h0403 || wl_wea2[wb+1] !== 2'b11) begin
      errors++;
      $display("FAIL small_burst_wrap got %h:%h %h:%h wea=%b, required ffe:0201 000:0403 11",
               wl_addr2[wb], wl_data2[wb], wl_addr2[wb+1], wl_data2[wb+1], wl_wea2[wb+1]);
    end
    wb = wl_addr2.size();
    send2(8'hF0); send2(8'h00); send2(8'h01); send2(8'h02); send2(8'h11);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_en2, tx_data2, addra2, wea2, dia2, addrb2, busy2} !== '0) begin
      errors++;
      $display("FAIL small_rst got aa=%h wea=%b dia=%h busy=%b, required all 0", addra2, wea2, dia2, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    txq2.delete();
    send2(8'hFF); send2(8'h34); send2(8'h02); send2(8'h35); send2(8'h02);
    wait_idle(2);
    checks++;
    if (wl_addr2.size() != wb || txq2.size() != 2 || txq2[0] !== 8'hCD || txq2[1] !== 8'hAB || addrb2 !== 12'h234) begin
      errors++;
      $display("FAIL small_read got writes=%0d count=%0d addrb=%h, required 0 writes, cd ab, addrb 234",
               wl_addr2.size() - wb, txq2.size(), addrb2);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    byte_done1 = 1'b0; rx1 = 8'h00;
    byte_done2 = 1'b0; rx2 = 8'h00;
    test_reset;
    test_ignore_opcode;
    test_single_write;
    test_burst_and_read;
    test_range_error;
    test_top_read;
    test_timeout;
    test_reset_mid_ops;
    test_small_cfg;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
